wb_master_bridge: RTL and testbench
===================================

// Module: wb_master_bridge
// PURPOSE
//  CPU-side Wishbone initiator for the MIO bus. Turns single CPU load/store
//  requests into one Wishbone classic cycle (cyc/stb/we/adr/dat) and waits for ack.
//  Captures read data, returns it to the CPU with a one-cycle done pulse, and
//  aborts with an error on timeout. Sits between the CPU memory port and the
//  peripheral bus decoder.
// PARAMETERS
//  TIMEOUT       16  cycles stb may stay high without ack before abort; 0 = never abort
//  ACK_DATA_LAT  1   cycles after the ack edge at which dat_i is sampled (0 = same edge)
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  rst        in   1   synchronous reset, active-high
//  cpu_req    in   1   request valid; accepted when cpu_req & cpu_ready
//  cpu_we     in   1   1 = store, 0 = load
//  cpu_addr   in   32  byte address
//  cpu_wdata  in   32  store data
//  cpu_ready  out  1   bridge idle, can accept a request
//  cpu_done   out  1   one-cycle pulse: transaction finished
//  cpu_err    out  1   high with cpu_done when transaction timed out
//  cpu_rdata  out  32  load data, valid while cpu_done=1, held until next done
//  adr_o      out  32  Wishbone address
//  dat_o      out  32  Wishbone write data
//  we_o       out  1   Wishbone write enable
//  cyc_o      out  1   Wishbone cycle
//  stb_o      out  1   Wishbone strobe
//  dat_i      in   32  Wishbone read data
//  ack_i      in   1   Wishbone acknowledge (may be combinational from stb_o)
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, cpu_ready=1, cpu_done=0, cpu_err=0,
//    cpu_rdata=0, adr_o=0, dat_o=0, we_o=0, cyc_o=0, stb_o=0, timer=0.
//  - States: IDLE, BUS, RDWAIT, DONE.
//  - IDLE: cpu_ready=1. On cpu_req: latch addr/wdata/we into adr_o/dat_o/we_o, set
//    cyc_o=stb_o=1, cpu_ready=0, clear timer -> BUS. Min request-to-stb latency 1 clk.
//  - BUS: timer increments each cycle while ack_i=0.
//    ack_i=1 & write         -> drop cyc/stb, -> DONE.
//    ack_i=1 & read & LAT=0  -> cpu_rdata<=dat_i, drop cyc/stb, -> DONE.
//    ack_i=1 & read & LAT>=1 -> drop cyc/stb, load lat counter, -> RDWAIT.
//    TIMEOUT!=0 & timer==TIMEOUT-1 & ack_i=0 -> drop cyc/stb, cpu_err<=1,
//    cpu_rdata<=0, -> DONE. Ack in the same cycle as expiry wins (no error).
//  - RDWAIT: after ACK_DATA_LAT clks (stb already low), cpu_rdata<=dat_i -> DONE.
//  - DONE: cpu_done=1 for exactly one clk (cpu_err as set); next edge -> IDLE,
//    cpu_err<=0, cpu_ready<=1. Write leaves cpu_rdata unchanged.
//  - Write txn: accept at edge N, stb high N+1.., ack-free slave => done at N+2.
//  - cpu_req while not ready is ignored (not queued); CPU must hold until ready.
//  - adr_o/dat_o/we_o stable for whole cycle; cyc_o==stb_o always.
//  - rst mid-transaction: next edge all outputs to reset values, no done pulse.
//  - timer width $clog2(TIMEOUT+1) (min 1); saturates, never wraps.
// STRUCTURE
//  - Shared package mio_bus_pkg: state encoding localparams, WB_ERR_DATA=32'h0,
//    MIO address constants (GPIO_LED=32'hFFFFFF00, COUNTER=32'hFFFFFF04,
//    GPIO_SEG=32'hFFFFFE00).
//  - One sub-module: wb_timeout_timer (clear, enable, expired) used in BUS.
// TESTING
//  1 Write 32'h0000_00A5 to FFFFFF00, slave ack=stb -> stb 1 clk, we_o=1,
//    dat_o=A5, cpu_done 2 clks after accept, cpu_err=0.
//  2 Read FFFFFE00, slave ack=stb, data 32'h1234_5678 one clk after ack,
//    LAT=1 -> cpu_rdata=12345678 with cpu_done, 3 clks after accept.
//  3 Read with ack held low, TIMEOUT=16 -> stb high exactly 16 clks, then
//    cpu_done=1, cpu_err=1, cpu_rdata=0; cpu_ready=1 next clk.
//  4 Ack in the expiry cycle (15 clks) -> cpu_err=0, data captured normally.
//  5 cpu_req toggled while busy -> exactly one Wishbone cycle issued; second
//    request accepted only after cpu_ready returns.
//  6 rst asserted while stb_o=1 -> next clk cyc/stb=0, cpu_ready=1, no done pulse;
//    new request then completes normally.

Source files
------------

// File: rtl/mio_bus_pkg.sv
// Shared definitions for the MIO bus: bridge FSM encoding, error data and
// the fixed peripheral addresses decoded downstream of the bridge.
package mio_bus_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUS    = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [31:0] WB_ERR_DATA = 32'h0000_0000;

    localparam logic [31:0] GPIO_LED = 32'hFFFF_FF00;
    localparam logic [31:0] COUNTER  = 32'hFFFF_FF04;
    localparam logic [31:0] GPIO_SEG = 32'hFFFF_FE00;

endpackage

// File: rtl/wb_timeout_timer.sv
// Saturating cycle counter that flags the last allowed strobe cycle of a
// Wishbone transfer; TIMEOUT of zero disables expiry.
module wb_timeout_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT != 0) && (r_count == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// CPU-side Wishbone classic initiator: one bus cycle per CPU load/store,
// optional delayed read-data capture and strobe timeout with error return.
module wb_master_bridge
    import mio_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned ACK_DATA_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    localparam int unsigned LW = (ACK_DATA_LAT <= 1) ? 1 : $clog2(ACK_DATA_LAT + 1);
    localparam logic [LW-1:0] LAT_LOAD = (ACK_DATA_LAT == 0) ? '0 : LW'(ACK_DATA_LAT - 1);

    logic [1:0]    r_state;
    logic          r_ready;
    logic          r_done;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [31:0]   r_adr;
    logic [31:0]   r_dat;
    logic          r_we;
    logic          r_cyc;
    logic [LW-1:0] r_lat;

    logic w_timer_clr;
    logic w_timer_en;
    logic w_expired;

    assign w_timer_clr = (r_state == ST_IDLE) && cpu_req;
    assign w_timer_en  = (r_state == ST_BUS) && !ack_i;

    wb_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clear   (w_timer_clr),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_lat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_adr   <= cpu_addr;
                        r_dat   <= cpu_wdata;
                        r_we    <= cpu_we;
                        r_cyc   <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // An ack arriving in the expiry cycle takes priority over the timeout.
                    if (ack_i) begin
                        r_cyc <= 1'b0;
                        if (r_we) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (ACK_DATA_LAT == 0) begin
                            r_rdata <= dat_i;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_lat   <= LAT_LOAD;
                            r_state <= ST_RDWAIT;
                        end
                    end else if (w_expired) begin
                        r_cyc   <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= WB_ERR_DATA;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_RDWAIT: begin
                    if (r_lat == '0) begin
                        r_rdata <= dat_i;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // cyc and stb share one register so they can never disagree.
    assign cpu_ready = r_ready;
    assign cpu_done  = r_done;
    assign cpu_err   = r_err;
    assign cpu_rdata = r_rdata;
    assign adr_o     = r_adr;
    assign dat_o     = r_dat;
    assign we_o      = r_we;
    assign cyc_o     = r_cyc;
    assign stb_o     = r_cyc;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge (TIMEOUT=16, ACK_DATA_LAT=1) with a
// small Wishbone slave whose ack delay and read data are set per vector.
module tb_wb_master_bridge;
    import mio_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic [31:0] dat_i;
    logic        ack_i;

    logic        ack_en   = 1'b0;
    int          ack_wait = 0;
    logic [31:0] rd_data  = '0;
    int          stb_cnt  = 0;
    logic        ack_d    = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Slave: ack after ack_wait strobe cycles, read data valid only the cycle after ack.
    assign ack_i = stb_o && ack_en && (stb_cnt >= ack_wait);
    assign dat_i = ack_d ? rd_data : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        stb_cnt <= stb_o ? stb_cnt + 1 : 0;
        ack_d   <= ack_i;
    end

    wb_master_bridge #(
        .TIMEOUT      (16),
        .ACK_DATA_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .we_o      (we_o),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ack_en;
        int          ack_wait;
        int          done_cyc;
        int          stb_cyc;
        logic        err;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic ack_en_v, input int ack_wait_v,
                                input int done_cyc, input int stb_cyc,
                                input logic err, input logic [31:0] exp_rdata);
        vec_t v;
        v.we        = we;
        v.addr      = addr;
        v.wdata     = wdata;
        v.rdata     = rdata;
        v.ack_en    = ack_en_v;
        v.ack_wait  = ack_wait_v;
        v.done_cyc  = done_cyc;
        v.stb_cyc   = stb_cyc;
        v.err       = err;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One transaction; cycle k=1 is the first cycle after the accepting edge.
    task automatic run_vec(input vec_t v, input int id);
        int   k;
        int   stb_cycles;
        logic done_seen;
        logic stable;
        @(negedge clk);
        check($sformatf("v%0d ready_before", id), cpu_ready, 1);
        cpu_req   = 1'b1;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        ack_en    = v.ack_en;
        ack_wait  = v.ack_wait;
        rd_data   = v.rdata;
        @(negedge clk);
        cpu_req   = 1'b0;
        cpu_we    = ~v.we;
        cpu_addr  = ~v.addr;
        cpu_wdata = ~v.wdata;
        check($sformatf("v%0d stb_first", id), stb_o, 1);
        check($sformatf("v%0d we_o", id), we_o, v.we);
        check($sformatf("v%0d adr_o", id), adr_o, v.addr);
        check($sformatf("v%0d dat_o", id), dat_o, v.wdata);
        k          = 1;
        stb_cycles = 0;
        done_seen  = 1'b0;
        stable     = 1'b1;
        while (!done_seen && k <= 40) begin
            if (stb_o) begin
                stb_cycles++;
                if (adr_o !== v.addr || dat_o !== v.wdata || we_o !== v.we) stable = 1'b0;
            end
            if (cyc_o !== stb_o) stable = 1'b0;
            if (cpu_done === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check($sformatf("v%0d done_seen", id), done_seen, 1);
        check($sformatf("v%0d done_cycle", id), k, v.done_cyc);
        check($sformatf("v%0d stb_cycles", id), stb_cycles, v.stb_cyc);
        check($sformatf("v%0d bus_stable", id), stable, 1);
        check($sformatf("v%0d err", id), cpu_err, v.err);
        check($sformatf("v%0d rdata", id), cpu_rdata, v.exp_rdata);
        check($sformatf("v%0d ready_at_done", id), cpu_ready, 0);
        @(negedge clk);
        check($sformatf("v%0d done_pulse", id), cpu_done, 0);
        check($sformatf("v%0d ready_after", id), cpu_ready, 1);
        check($sformatf("v%0d err_after", id), cpu_err, 0);
        check($sformatf("v%0d rdata_held", id), cpu_rdata, v.exp_rdata);
        check($sformatf("v%0d stb_after", id), stb_o, 0);
    endtask

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int   starts;
        logic prev_cyc;
        logic seen;
        logic ok;

        vecs[0] = mk(1'b1, GPIO_LED, 32'h0000_00A5, 32'h0, 1'b1, 0, 2, 1, 1'b0, 32'h0);
        vecs[1] = mk(1'b0, GPIO_SEG, 32'h0, 32'h1234_5678, 1'b1, 0, 3, 1, 1'b0, 32'h1234_5678);
        vecs[2] = mk(1'b0, COUNTER, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 17, 16, 1'b1, 32'h0);
        vecs[3] = mk(1'b0, COUNTER, 32'h0, 32'hCAFE_F00D, 1'b1, 15, 18, 16, 1'b0, 32'hCAFE_F00D);
        vecs[4] = mk(1'b1, GPIO_SEG, 32'h0000_55AA, 32'h0, 1'b1, 3, 5, 4, 1'b0, 32'hCAFE_F00D);
        vecs[5] = mk(1'b0, GPIO_LED, 32'h0, 32'h0BAD_C0DE, 1'b1, 14, 17, 15, 1'b0, 32'h0BAD_C0DE);
        vecs[6] = mk(1'b1, GPIO_LED, 32'h0000_1234, 32'h0, 1'b0, 0, 17, 16, 1'b1, 32'h0);
        vecs[7] = mk(1'b1, GPIO_SEG, 32'h0000_0009, 32'h0, 1'b1, 0, 2, 1, 1'b0, 32'h0);

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset ready", cpu_ready, 1);
        check("reset done", cpu_done, 0);
        check("reset err", cpu_err, 0);
        check("reset rdata", cpu_rdata, 0);
        check("reset cyc", cyc_o, 0);
        check("reset stb", stb_o, 0);
        check("reset adr", adr_o, 0);
        check("reset dat", dat_o, 0);
        check("reset we", we_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Requests toggling while busy must not start a second bus cycle.
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = GPIO_LED;
        cpu_wdata = '0;
        ack_en    = 1'b1;
        ack_wait  = 5;
        rd_data   = 32'h1111_1111;
        starts    = 0;
        prev_cyc  = 1'b0;
        seen      = 1'b0;
        ok        = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (cyc_o && !prev_cyc) starts++;
            prev_cyc = cyc_o;
            if (cyc_o && (adr_o !== GPIO_LED || we_o !== 1'b0)) ok = 1'b0;
            if (cpu_done === 1'b1) begin
                seen    = 1'b1;
                cpu_req = 1'b0;
            end else begin
                cpu_req   = ~cpu_req;
                cpu_we    = 1'b1;
                cpu_addr  = COUNTER;
                cpu_wdata = 32'h0000_0077;
            end
        end
        check("busy done_seen", seen, 1);
        check("busy cycle_starts", starts, 1);
        check("busy first_cycle_kept", ok, 1);
        check("busy rdata", cpu_rdata, 32'h1111_1111);
        @(negedge clk);
        check("busy ready_returns", cpu_ready, 1);
        check("busy no_second_cycle", cyc_o, 0);
        run_vec(mk(1'b1, COUNTER, 32'h0000_0077, 32'h0, 1'b1, 0, 2, 1, 1'b0, 32'h1111_1111), 10);

        // Reset while the strobe is up aborts silently.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = GPIO_LED;
        ack_en   = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid stb_before", stb_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid cyc", cyc_o, 0);
        check("rst_mid stb", stb_o, 0);
        check("rst_mid ready", cpu_ready, 1);
        check("rst_mid done", cpu_done, 0);
        check("rst_mid adr", adr_o, 0);
        check("rst_mid rdata", cpu_rdata, 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_done || cyc_o) seen = 1'b1;
        end
        check("rst_mid no_done_pulse", seen, 0);
        run_vec(mk(1'b0, COUNTER, 32'h0, 32'h600D_D00D, 1'b1, 0, 3, 1, 1'b0, 32'h600D_D00D), 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
